// File: rtl/axi_sync_buffer_if.sv
// AXI channel bundle shared by the upstream (S) and downstream (M) sides of
// axi_sync_buffer. Field widths: ID 4, ADDR 32, DATA 32, LEN 8, STRB 4, RESP 2.
interface AXI_INF;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport S (
    input  awid, awaddr, awlen, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  arid, araddr, arlen, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );

  modport M (
    output awid, awaddr, awlen, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready
  );
endinterface

// File: rtl/axi_sync_buffer.sv
// Five-channel AXI register-slice style buffer: one synchronous FIFO per
// channel, plus write/read outstanding-transaction limiters on AW and AR.

// Synchronous FIFO with DEPTH_LOG2+1 bit pointers (the extra MSB separates
// full from empty). The head entry is read straight from the storage flops.
module axi_sync_buffer_fifo #(
  parameter int DEPTH_LOG2 = 2,
  parameter int WIDTH      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PTR_W = DEPTH_LOG2 + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  assign full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                 (wr_ptr_q[PTR_W-2:0] == rd_ptr_q[PTR_W-2:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign dout  = mem_q[rd_ptr_q[PTR_W-2:0]];

  // Next pointers and storage: a push writes the tail, a pop advances the head.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push && !full) begin
      mem_d[wr_ptr_q[PTR_W-2:0]] = din;
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer and storage registers; reset drops every buffered beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end
endmodule

module axi_sync_buffer #(
  parameter int DEPTH_LOG2   = 2,
  parameter int MAX_WR_OUTST = 4,
  parameter int MAX_RD_OUTST = 4
) (
  input  logic       BUS_CLK,
  input  logic       BUS_RSTN,
  AXI_INF.S          AXI_S,
  AXI_INF.M          AXI_M,
  output logic [4:0] fifo_empty_flag,
  output logic [7:0] wr_outstanding,
  output logic [7:0] rd_outstanding
);
  localparam int AW_W = 44;
  localparam int W_W  = 37;
  localparam int B_W  = 6;
  localparam int AR_W = 44;
  localparam int R_W  = 39;
  localparam logic [7:0] MAX_WR = 8'(MAX_WR_OUTST);
  localparam logic [7:0] MAX_RD = 8'(MAX_RD_OUTST);

  // Channel index: 0 AW, 1 W, 2 B, 3 AR, 4 R.
  logic [4:0]      full_s, empty_s;
  logic [AW_W-1:0] aw_dout_s;
  logic [W_W-1:0]  w_dout_s;
  logic [B_W-1:0]  b_dout_s;
  logic [AR_W-1:0] ar_dout_s;
  logic [R_W-1:0]  r_dout_s;
  logic            aw_push_s, w_push_s, b_push_s, ar_push_s, r_push_s;
  logic            aw_pop_s, w_pop_s, b_pop_s, ar_pop_s, r_pop_s;
  logic            rlast_hs_s;

  // Ready is held low until the first clock edge after reset release.
  logic       ready_en_q, ready_en_d;
  logic [7:0] wr_cnt_q, wr_cnt_d;
  logic [7:0] rd_cnt_q, rd_cnt_d;
  logic [4:0] empty_flag_q, empty_flag_d;

  // Input-side readies depend only on registered state, never on a same-cycle pop.
  assign AXI_S.awready = ready_en_q && !full_s[0] && (wr_cnt_q < MAX_WR);
  assign AXI_S.wready  = ready_en_q && !full_s[1];
  assign AXI_M.bready  = ready_en_q && !full_s[2];
  assign AXI_S.arready = ready_en_q && !full_s[3] && (rd_cnt_q < MAX_RD);
  assign AXI_M.rready  = ready_en_q && !full_s[4];

  assign AXI_M.awvalid = !empty_s[0];
  assign AXI_M.wvalid  = !empty_s[1];
  assign AXI_S.bvalid  = !empty_s[2];
  assign AXI_M.arvalid = !empty_s[3];
  assign AXI_S.rvalid  = !empty_s[4];

  assign {AXI_M.awid, AXI_M.awaddr, AXI_M.awlen}             = aw_dout_s;
  assign {AXI_M.wdata, AXI_M.wstrb, AXI_M.wlast}             = w_dout_s;
  assign {AXI_S.bid, AXI_S.bresp}                            = b_dout_s;
  assign {AXI_M.arid, AXI_M.araddr, AXI_M.arlen}             = ar_dout_s;
  assign {AXI_S.rid, AXI_S.rdata, AXI_S.rresp, AXI_S.rlast}  = r_dout_s;

  assign aw_push_s  = AXI_S.awvalid && AXI_S.awready;
  assign w_push_s   = AXI_S.wvalid  && AXI_S.wready;
  assign b_push_s   = AXI_M.bvalid  && AXI_M.bready;
  assign ar_push_s  = AXI_S.arvalid && AXI_S.arready;
  assign r_push_s   = AXI_M.rvalid  && AXI_M.rready;
  assign aw_pop_s   = AXI_M.awvalid && AXI_M.awready;
  assign w_pop_s    = AXI_M.wvalid  && AXI_M.wready;
  assign b_pop_s    = AXI_S.bvalid  && AXI_S.bready;
  assign ar_pop_s   = AXI_M.arvalid && AXI_M.arready;
  assign r_pop_s    = AXI_S.rvalid  && AXI_S.rready;
  assign rlast_hs_s = r_pop_s && AXI_S.rlast;

  assign fifo_empty_flag = empty_flag_q;
  assign wr_outstanding  = wr_cnt_q;
  assign rd_outstanding  = rd_cnt_q;

  axi_sync_buffer_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(AW_W)) u_aw_fifo (
    .clk(BUS_CLK), .rst_n(BUS_RSTN), .push(aw_push_s),
    .din({AXI_S.awid, AXI_S.awaddr, AXI_S.awlen}),
    .pop(aw_pop_s), .dout(aw_dout_s), .full(full_s[0]), .empty(empty_s[0]));

  axi_sync_buffer_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(W_W)) u_w_fifo (
    .clk(BUS_CLK), .rst_n(BUS_RSTN), .push(w_push_s),
    .din({AXI_S.wdata, AXI_S.wstrb, AXI_S.wlast}),
    .pop(w_pop_s), .dout(w_dout_s), .full(full_s[1]), .empty(empty_s[1]));

  axi_sync_buffer_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(B_W)) u_b_fifo (
    .clk(BUS_CLK), .rst_n(BUS_RSTN), .push(b_push_s),
    .din({AXI_M.bid, AXI_M.bresp}),
    .pop(b_pop_s), .dout(b_dout_s), .full(full_s[2]), .empty(empty_s[2]));

  axi_sync_buffer_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(AR_W)) u_ar_fifo (
    .clk(BUS_CLK), .rst_n(BUS_RSTN), .push(ar_push_s),
    .din({AXI_S.arid, AXI_S.araddr, AXI_S.arlen}),
    .pop(ar_pop_s), .dout(ar_dout_s), .full(full_s[3]), .empty(empty_s[3]));

  axi_sync_buffer_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(R_W)) u_r_fifo (
    .clk(BUS_CLK), .rst_n(BUS_RSTN), .push(r_push_s),
    .din({AXI_M.rid, AXI_M.rdata, AXI_M.rresp, AXI_M.rlast}),
    .pop(r_pop_s), .dout(r_dout_s), .full(full_s[4]), .empty(empty_s[4]));

  // Outstanding counters: saturating, hold on simultaneous inc/dec; a stray
  // B or RLAST at zero is ignored while the beat itself is still forwarded.
  always_comb begin
    ready_en_d   = 1'b1;
    empty_flag_d = empty_s;
    wr_cnt_d     = wr_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    if (aw_push_s && !b_pop_s && (wr_cnt_q < MAX_WR)) begin
      wr_cnt_d = wr_cnt_q + 8'd1;
    end else if (b_pop_s && !aw_push_s && (wr_cnt_q != 8'd0)) begin
      wr_cnt_d = wr_cnt_q - 8'd1;
    end else begin
      wr_cnt_d = wr_cnt_q;
    end
    if (ar_push_s && !rlast_hs_s && (rd_cnt_q < MAX_RD)) begin
      rd_cnt_d = rd_cnt_q + 8'd1;
    end else if (rlast_hs_s && !ar_push_s && (rd_cnt_q != 8'd0)) begin
      rd_cnt_d = rd_cnt_q - 8'd1;
    end else begin
      rd_cnt_d = rd_cnt_q;
    end
  end

  // Control registers: ready enable, outstanding counters, delayed empty flags.
  always_ff @(posedge BUS_CLK or negedge BUS_RSTN) begin
    if (!BUS_RSTN) begin
      ready_en_q   <= 1'b0;
      wr_cnt_q     <= 8'd0;
      rd_cnt_q     <= 8'd0;
      empty_flag_q <= 5'b11111;
    end else begin
      ready_en_q   <= ready_en_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      empty_flag_q <= empty_flag_d;
    end
  end
endmodule

// File: tb/tb_axi_sync_buffer.sv
// Bench for axi_sync_buffer: queue-based channel model checked every negedge,
// plus directed scenarios with hand-computed literal expectations.
module tb_axi_sync_buffer;
  localparam int DEPTH = 4;
  localparam int MAXW  = 4;
  localparam int MAXR  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] fifo_empty_flag;
  logic [7:0] wr_outstanding;
  logic [7:0] rd_outstanding;

  AXI_INF s_if();
  AXI_INF m_if();

  axi_sync_buffer #(.DEPTH_LOG2(2), .MAX_WR_OUTST(MAXW), .MAX_RD_OUTST(MAXR)) dut (
    .BUS_CLK(clk), .BUS_RSTN(rst_n), .AXI_S(s_if), .AXI_M(m_if),
    .fifo_empty_flag(fifo_empty_flag), .wr_outstanding(wr_outstanding),
    .rd_outstanding(rd_outstanding));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    s_if.awvalid = 1'b0; s_if.awid = 4'd0; s_if.awaddr = 32'd0; s_if.awlen = 8'd0;
    s_if.wvalid = 1'b0; s_if.wdata = 32'd0; s_if.wstrb = 4'd0; s_if.wlast = 1'b0;
    s_if.bready = 1'b0;
    s_if.arvalid = 1'b0; s_if.arid = 4'd0; s_if.araddr = 32'd0; s_if.arlen = 8'd0;
    s_if.rready = 1'b0;
    m_if.awready = 1'b0; m_if.wready = 1'b0; m_if.arready = 1'b0;
    m_if.bvalid = 1'b0; m_if.bid = 4'd0; m_if.bresp = 2'd0;
    m_if.rvalid = 1'b0; m_if.rid = 4'd0; m_if.rdata = 32'd0; m_if.rresp = 2'd0; m_if.rlast = 1'b0;
  endtask

  // Model: channel contents as queues, counters as integers.
  logic [43:0] q_aw[$];
  logic [36:0] q_w[$];
  logic [5:0]  q_b[$];
  logic [43:0] q_ar[$];
  logic [38:0] q_r[$];
  bit          m_en;
  int          m_wr, m_rd;
  logic [4:0]  m_flag;
  bit e_awrdy, e_wrdy, e_brdy, e_arrdy, e_rrdy, aw_hs, b_hs, ar_hs, rl_hs;

  // Compare process: checks DUT against model at negedge, then advances the
  // model to the state it must hold after the coming posedge.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      q_aw.delete(); q_w.delete(); q_b.delete(); q_ar.delete(); q_r.delete();
      m_en = 1'b0; m_wr = 0; m_rd = 0; m_flag = 5'h1f;
    end
    e_awrdy = m_en && (q_aw.size() < DEPTH) && (m_wr < MAXW);
    e_wrdy  = m_en && (q_w.size() < DEPTH);
    e_brdy  = m_en && (q_b.size() < DEPTH);
    e_arrdy = m_en && (q_ar.size() < DEPTH) && (m_rd < MAXR);
    e_rrdy  = m_en && (q_r.size() < DEPTH);
    chk("m_s_awready", s_if.awready, e_awrdy);
    chk("m_s_wready", s_if.wready, e_wrdy);
    chk("m_m_bready", m_if.bready, e_brdy);
    chk("m_s_arready", s_if.arready, e_arrdy);
    chk("m_m_rready", m_if.rready, e_rrdy);
    chk("m_m_awvalid", m_if.awvalid, q_aw.size() != 0);
    chk("m_m_wvalid", m_if.wvalid, q_w.size() != 0);
    chk("m_s_bvalid", s_if.bvalid, q_b.size() != 0);
    chk("m_m_arvalid", m_if.arvalid, q_ar.size() != 0);
    chk("m_s_rvalid", s_if.rvalid, q_r.size() != 0);
    if (q_aw.size() != 0) chk("m_aw_payload", {m_if.awid, m_if.awaddr, m_if.awlen}, q_aw[0]);
    if (q_w.size() != 0)  chk("m_w_payload", {m_if.wdata, m_if.wstrb, m_if.wlast}, q_w[0]);
    if (q_b.size() != 0)  chk("m_b_payload", {s_if.bid, s_if.bresp}, q_b[0]);
    if (q_ar.size() != 0) chk("m_ar_payload", {m_if.arid, m_if.araddr, m_if.arlen}, q_ar[0]);
    if (q_r.size() != 0)  chk("m_r_payload", {s_if.rid, s_if.rdata, s_if.rresp, s_if.rlast}, q_r[0]);
    chk("m_empty_flag", fifo_empty_flag, m_flag);
    chk("m_wr_outstanding", wr_outstanding, 8'(m_wr));
    chk("m_rd_outstanding", rd_outstanding, 8'(m_rd));
    if (rst_n) begin
      aw_hs = s_if.awvalid && e_awrdy;
      b_hs  = (q_b.size() != 0) && s_if.bready;
      ar_hs = s_if.arvalid && e_arrdy;
      rl_hs = (q_r.size() != 0) && s_if.rready && q_r[0][0];
      m_flag = {q_r.size() == 0, q_ar.size() == 0, q_b.size() == 0, q_w.size() == 0, q_aw.size() == 0};
      if (q_aw.size() != 0 && m_if.awready) q_aw.delete(0);
      if (q_w.size() != 0 && m_if.wready)   q_w.delete(0);
      if (q_b.size() != 0 && s_if.bready)   q_b.delete(0);
      if (q_ar.size() != 0 && m_if.arready) q_ar.delete(0);
      if (q_r.size() != 0 && s_if.rready)   q_r.delete(0);
      if (aw_hs) q_aw.push_back({s_if.awid, s_if.awaddr, s_if.awlen});
      if (s_if.wvalid && e_wrdy) q_w.push_back({s_if.wdata, s_if.wstrb, s_if.wlast});
      if (m_if.bvalid && e_brdy) q_b.push_back({m_if.bid, m_if.bresp});
      if (ar_hs) q_ar.push_back({s_if.arid, s_if.araddr, s_if.arlen});
      if (m_if.rvalid && e_rrdy) q_r.push_back({m_if.rid, m_if.rdata, m_if.rresp, m_if.rlast});
      if (aw_hs && !b_hs) m_wr++;
      else if (b_hs && !aw_hs && m_wr > 0) m_wr--;
      if (ar_hs && !rl_hs) m_rd++;
      else if (rl_hs && !ar_hs && m_rd > 0) m_rd--;
      m_en = 1'b1;
    end
  end

  // Directed scenarios followed by random stress; inputs change at posedge+1.
  initial begin
    clear_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_flags", fifo_empty_flag, 5'h1f);
    chk("rst_awready", s_if.awready, 1'b0);
    chk("rst_bready", m_if.bready, 1'b0);
    chk("rst_wr_out", wr_outstanding, 8'd0);
    rst_n = 1'b1;
    #1;
    chk("release_ready_low", s_if.wready, 1'b0);
    tick();
    chk("release_ready_high", s_if.wready, 1'b1);

    // Single write: AW id 3 + one W beat, then B OKAY id 3.
    s_if.awvalid = 1'b1; s_if.awid = 4'd3; s_if.awaddr = 32'h1000; s_if.awlen = 8'd0;
    s_if.wvalid = 1'b1; s_if.wdata = 32'hCAFE0001; s_if.wstrb = 4'hF; s_if.wlast = 1'b1;
    tick();
    s_if.awvalid = 1'b0; s_if.wvalid = 1'b0;
    chk("t1_m_awvalid", m_if.awvalid, 1'b1);
    chk("t1_m_awid", m_if.awid, 4'd3);
    chk("t1_m_wvalid", m_if.wvalid, 1'b1);
    chk("t1_m_wdata", m_if.wdata, 32'hCAFE0001);
    chk("t1_wr_out_1", wr_outstanding, 8'd1);
    m_if.awready = 1'b1; m_if.wready = 1'b1;
    tick();
    chk("t1_aw_popped", m_if.awvalid, 1'b0);
    m_if.awready = 1'b0; m_if.wready = 1'b0;
    m_if.bvalid = 1'b1; m_if.bid = 4'd3; m_if.bresp = 2'd0;
    tick();
    m_if.bvalid = 1'b0;
    chk("t1_s_bvalid", s_if.bvalid, 1'b1);
    chk("t1_s_bid", s_if.bid, 4'd3);
    chk("t1_s_bresp", s_if.bresp, 2'd0);
    s_if.bready = 1'b1;
    tick();
    s_if.bready = 1'b0;
    chk("t1_wr_out_0", wr_outstanding, 8'd0);

    // W FIFO full: 5 beats offered with downstream stalled.
    for (int i = 0; i < 4; i++) begin
      s_if.wvalid = 1'b1; s_if.wdata = 32'h100 + 32'(i); s_if.wlast = (i == 3);
      tick();
    end
    s_if.wdata = 32'h104; s_if.wlast = 1'b0;
    chk("t2_full_wready", s_if.wready, 1'b0);
    tick();
    s_if.wvalid = 1'b0;
    chk("t2_still_full", s_if.wready, 1'b0);
    m_if.wready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_order", m_if.wdata, 32'h100 + 32'(i));
      tick();
    end
    m_if.wready = 1'b0;
    chk("t2_flag_lag", fifo_empty_flag[1], 1'b0);
    tick();
    chk("t2_flag_back", fifo_empty_flag[1], 1'b1);

    // Read outstanding limit of 2; third AR waits for RLAST.
    m_if.arready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      s_if.arvalid = 1'b1; s_if.arid = 4'(i + 1); s_if.araddr = 32'h2000 + 32'(i * 64); s_if.arlen = 8'd3;
      tick();
    end
    s_if.arid = 4'd3; s_if.araddr = 32'h2080;
    chk("t3_arready_block", s_if.arready, 1'b0);
    chk("t3_rd_out_2", rd_outstanding, 8'd2);
    s_if.rready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      m_if.rvalid = 1'b1; m_if.rid = 4'd1; m_if.rdata = 32'hD000 + 32'(k); m_if.rresp = 2'd0; m_if.rlast = (k == 3);
      tick();
      chk("t3_rdata", s_if.rdata, 32'hD000 + 32'(k));
    end
    m_if.rvalid = 1'b0; m_if.rlast = 1'b0;
    chk("t3_before_last", rd_outstanding, 8'd2);
    tick();
    chk("t3_on_last", rd_outstanding, 8'd1);
    chk("t3_arready_free", s_if.arready, 1'b1);
    tick();
    chk("t3_third_ar", rd_outstanding, 8'd2);
    s_if.arvalid = 1'b0; s_if.rready = 1'b0; m_if.arready = 1'b0;

    rst_n = 1'b0;
    tick();
    clear_inputs();
    rst_n = 1'b1;
    tick();

    // Simultaneous AW and B at wr_outstanding 2; push+pop on half-full W.
    m_if.awready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      s_if.awvalid = 1'b1; s_if.awid = 4'(i); s_if.awaddr = 32'h3000 + 32'(i);
      tick();
    end
    s_if.awvalid = 1'b0;
    chk("t4_wr_out_2", wr_outstanding, 8'd2);
    m_if.bvalid = 1'b1; m_if.bid = 4'd5; m_if.bresp = 2'd2;
    tick();
    m_if.bvalid = 1'b0;
    chk("t4_bresp_fwd", s_if.bresp, 2'd2);
    s_if.awvalid = 1'b1; s_if.awid = 4'd7; s_if.bready = 1'b1;
    tick();
    s_if.awvalid = 1'b0; s_if.bready = 1'b0;
    chk("t4_hold_2", wr_outstanding, 8'd2);
    chk("t4_b_gone", s_if.bvalid, 1'b0);
    for (int i = 0; i < 2; i++) begin
      s_if.wvalid = 1'b1; s_if.wdata = 32'h300 + 32'(i); s_if.wstrb = 4'h3;
      tick();
    end
    s_if.wdata = 32'h302; m_if.wready = 1'b1;
    tick();
    s_if.wvalid = 1'b0; m_if.wready = 1'b0;
    chk("t4_head_after_swap", m_if.wdata, 32'h301);
    chk("t4_not_full", s_if.wready, 1'b1);

    // Reset with three R beats queued.
    m_if.awready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      m_if.rvalid = 1'b1; m_if.rid = 4'd9; m_if.rdata = 32'hE00 + 32'(k);
      tick();
    end
    m_if.rvalid = 1'b0;
    chk("t5_rvalid_before", s_if.rvalid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rvalid_async", s_if.rvalid, 1'b0);
    chk("t5_flags", fifo_empty_flag, 5'h1f);
    chk("t5_wr_out", wr_outstanding, 8'd0);
    chk("t5_rd_out", rd_outstanding, 8'd0);
    chk("t5_rready", m_if.rready, 1'b0);
    tick();
    clear_inputs();
    rst_n = 1'b1;
    tick();
    s_if.rready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t5_no_stale", s_if.rvalid, 1'b0);
    end

    // Random stress on both sides.
    for (int c = 0; c < 10000; c++) begin
      s_if.awvalid = 1'($urandom_range(0, 1)); s_if.awid = 4'($urandom); s_if.awaddr = $urandom; s_if.awlen = 8'($urandom);
      s_if.wvalid = 1'($urandom_range(0, 1)); s_if.wdata = $urandom; s_if.wstrb = 4'($urandom); s_if.wlast = 1'($urandom);
      s_if.bready = 1'($urandom_range(0, 1));
      s_if.arvalid = 1'($urandom_range(0, 1)); s_if.arid = 4'($urandom); s_if.araddr = $urandom; s_if.arlen = 8'($urandom);
      s_if.rready = 1'($urandom_range(0, 1));
      m_if.awready = 1'($urandom_range(0, 1)); m_if.wready = 1'($urandom_range(0, 1)); m_if.arready = 1'($urandom_range(0, 1));
      m_if.bvalid = 1'($urandom_range(0, 1)); m_if.bid = 4'($urandom); m_if.bresp = 2'($urandom);
      m_if.rvalid = 1'($urandom_range(0, 1)); m_if.rid = 4'($urandom); m_if.rdata = $urandom;
      m_if.rresp = 2'($urandom); m_if.rlast = 1'($urandom);
      tick();
      chk("rnd_wr_le_max", wr_outstanding <= 8'd4, 1'b1);
      chk("rnd_rd_le_max", rd_outstanding <= 8'd2, 1'b1);
    end
    clear_inputs();
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule

// File: doc/axi_sync_buffer.md
AXI_SYNC_BUFFER -- requirements
Module: axi_sync_buffer

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 2, meaning log2 of per-channel FIFO depth (DEPTH = 2**DEPTH_LOG2, legal range 1..6).
REQ-002 SHALL have parameter MAX_WR_OUTST, default 4, meaning the maximum number of accepted AW not yet answered by B (legal range 1..255).
REQ-003 SHALL have parameter MAX_RD_OUTST, default 4, meaning the maximum number of accepted AR whose RLAST has not yet been returned (legal range 1..255).
REQ-004 SHALL have port BUS_CLK  input  1  single clock for all logic.
REQ-005 SHALL have port BUS_RSTN  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port AXI_S  AXI_INF.S  -  upstream side; AW, W and AR are received and B and R are driven here.
REQ-007 SHALL have port AXI_M  AXI_INF.M  -  downstream side; AW, W and AR are driven and B and R are received here.
REQ-008 SHALL have port fifo_empty_flag  output  5  empty flags: bit0 AW, bit1 W, bit2 B, bit3 AR, bit4 R.
REQ-009 SHALL have port wr_outstanding  output  8  current write outstanding count.
REQ-010 SHALL have port rd_outstanding  output  8  current read outstanding count.

Function
REQ-011 SHALL buffer each of the five AXI channels in an independent synchronous FIFO of DEPTH entries that carries every payload field of that channel.
REQ-012 Each FIFO SHALL use read/write pointers of DEPTH_LOG2+1 bits; full = MSBs differ and LSBs are equal; empty = pointers are equal; wrap-around is by natural overflow.
REQ-013 Input ready SHALL equal !full and SHALL NOT depend on a same-cycle pop, so a full FIFO never accepts a beat.
REQ-014 Output valid SHALL equal !empty and output data SHALL be the registered head entry, giving a minimum latency of 1 cycle from input handshake to output valid.
REQ-015 A simultaneous push and pop on a non-full, non-empty FIFO SHALL leave occupancy unchanged and preserve order.
REQ-016 Once output valid is high it SHALL stay high with stable payload until the ready handshake completes.
REQ-017 AXI_S AWREADY SHALL be !full(AW) && (wr_outstanding < MAX_WR_OUTST).
REQ-018 wr_outstanding SHALL increment on an AXI_S AW handshake and decrement on an AXI_S B handshake; when both occur in the same cycle it SHALL hold.
REQ-019 AXI_S ARREADY SHALL be !full(AR) && (rd_outstanding < MAX_RD_OUTST).
REQ-020 rd_outstanding SHALL increment on an AXI_S AR handshake and decrement on an AXI_S R handshake with RLAST=1; when both occur in the same cycle it SHALL hold.
REQ-021 The counters SHALL saturate: no increment at MAX and no decrement at 0. A B or RLAST arriving at count 0 is a protocol error, is ignored, and the beat is still forwarded.
REQ-022 W beats SHALL be accepted independently of AW; no write-data-before-address restriction is imposed.
REQ-023 The block SHALL NOT reorder, merge, split or modify any beat or field, including ID, LAST, RESP and STRB.
REQ-024 fifo_empty_flag[n] SHALL be a registered copy of the empty status of FIFO n, lagging by 1 cycle.

Reset
REQ-025 While BUS_RSTN=0 all pointers, counters and output registers SHALL clear asynchronously.
REQ-026 During reset all VALID outputs SHALL be 0, all READY outputs SHALL be 0, fifo_empty_flag SHALL be 5'b11111, and wr_outstanding and rd_outstanding SHALL be 0.
REQ-027 Reset release SHALL be synchronous to BUS_CLK, and READY outputs SHALL rise no earlier than the first BUS_CLK edge after release.
REQ-028 A reset asserted mid-burst SHALL discard all buffered beats without emitting partial data; recovery of the upstream and downstream protocols is their responsibility.

Verification
REQ-029 Single write with DEPTH_LOG2=2: AW(id=3) and 1 W beat (LAST=1), then B OKAY -> downstream AW/W VALID 1 cycle after the handshake; wr_outstanding 0->1->0; B id=3 forwarded upstream.
REQ-030 FIFO full: hold AXI_M WREADY=0 and push 5 W beats -> 4 accepted, WREADY upstream=0 on the 5th; release -> 4 beats emitted in order; fifo_empty_flag[1] returns to 1 one cycle after the last pop.
REQ-031 Outstanding limit with MAX_RD_OUTST=2: issue 3 ARs with R stalled -> 3rd ARREADY=0; R burst of 4 beats with LAST on the 4th -> rd_outstanding drops to 1 only on the LAST beat and the 3rd AR is accepted the next cycle.
REQ-032 Simultaneous events: AW handshake and B handshake in the same cycle at wr_outstanding=2 -> stays 2; push and pop on a half-full FIFO -> occupancy unchanged.
REQ-033 Reset mid-operation: assert BUS_RSTN=0 with 3 beats queued in R -> RVALID=0 immediately (asynchronous), flags 11111, counts 0; after release no stale beat appears.
REQ-034 Random stress: random VALID/READY on both sides for 10k cycles -> scoreboard shows per-channel order and payloads exact, no beat lost or duplicated, and the counters never exceed MAX.
